// File: rtl/hist_portb_ctrl_pkg.sv
// Shared CLAHE histogram constants and the port-B controller FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_portb_ctrl_pkg;

    localparam int HIST_TILES  = 32;
    localparam int HIST_BINS   = 256;
    localparam int HIST_DW     = 16;
    localparam int HIST_AW     = 8;
    localparam int HIST_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_CLR  = 3'd4
    } st_e;

endpackage

// File: rtl/hist_portb_ctrl_if.sv
// Bundle of the init-sequencer, RAM port-B and CDF-stream signals of the controller.
// Latency: n/a (wiring only).
// Backpressure: none; the histogram stream is push-only.
interface hist_portb_ctrl_if #(
    parameter int TILES = hist_portb_ctrl_pkg::HIST_TILES,
    parameter int DW    = hist_portb_ctrl_pkg::HIST_DW
);
    localparam int AW = hist_portb_ctrl_pkg::HIST_AW;

    logic                  init_flag;
    logic [AW-1:0]         init_addr;
    logic [DW-1:0]         init_data;
    logic [TILES-1:0]      init_wren;
    logic [TILES*DW-1:0]   portb_q;
    logic [AW-1:0]         portb_addr;
    logic [DW-1:0]         portb_data;
    logic [TILES-1:0]      portb_wren;
    logic                  hist_out_valid;
    logic [AW-1:0]         hist_out_bin;
    logic [TILES*DW-1:0]   hist_out_data;

    // Controller side.
    modport slave (
        input  init_flag, init_addr, init_data, init_wren, portb_q,
        output portb_addr, portb_data, portb_wren,
        output hist_out_valid, hist_out_bin, hist_out_data
    );

    // Environment side: init sequencer, RAMs and CDF consumer.
    modport master (
        output init_flag, init_addr, init_data, init_wren, portb_q,
        input  portb_addr, portb_data, portb_wren,
        input  hist_out_valid, hist_out_bin, hist_out_data
    );

endinterface

// File: rtl/hist_bin_sweeper.sv
// Controller FSM: init hand-off plus the RD/WAIT/CLR bin sweep and its 9-bit bin counter.
// Latency: 1+RD_LAT cycles per bin, BINS*(1+RD_LAT) per sweep.
// Backpressure: none; once started the sweep runs to the last bin.
module hist_bin_sweeper
    import hist_portb_ctrl_pkg::*;
#(
    parameter int BINS   = HIST_BINS,
    parameter int RD_LAT = HIST_RD_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_flag,
    input  logic       start,
    output st_e        st_q,
    output st_e        st_nxt,
    output logic [7:0] cur_bin,
    output logic [7:0] nxt_bin,
    output logic       last_bin
);
    localparam int         WCW  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [8:0] LAST = 9'(BINS - 1);

    // The counter is one bit wider than the address so the last-bin test never aliases.
    logic [8:0]     bin_q;
    logic [8:0]     bin_nxt;
    logic [WCW-1:0] wcnt_q;
    logic [WCW-1:0] wcnt_nxt;

    assign last_bin = (bin_q == LAST);
    assign cur_bin  = bin_q[7:0];
    assign nxt_bin  = bin_nxt[7:0];

    // State, bin counter and read-latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            bin_q  <= '0;
            wcnt_q <= '0;
        end else begin
            st_q   <= st_nxt;
            bin_q  <= bin_nxt;
            wcnt_q <= wcnt_nxt;
        end
    end

    // Next state: init wins over a sweep start in IDLE; sweep states ignore init_flag.
    always_comb begin
        st_nxt   = st_q;
        bin_nxt  = bin_q;
        wcnt_nxt = wcnt_q;
        unique case (st_q)
            ST_IDLE: begin
                if (init_flag) begin
                    st_nxt = ST_INIT;
                end else if (start) begin
                    st_nxt  = ST_RD;
                    bin_nxt = '0;
                end
            end
            ST_INIT: begin
                if (!init_flag) st_nxt = ST_IDLE;
            end
            ST_RD: begin
                wcnt_nxt = '0;
                st_nxt   = (RD_LAT > 1) ? ST_WAIT : ST_CLR;
            end
            ST_WAIT: begin
                if (wcnt_q == WCW'(RD_LAT - 2)) st_nxt = ST_CLR;
                else                            wcnt_nxt = wcnt_q + WCW'(1);
            end
            ST_CLR: begin
                if (last_bin) begin
                    st_nxt = ST_IDLE;
                end else begin
                    st_nxt  = ST_RD;
                    bin_nxt = bin_q + 9'd1;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/hist_portb_ctrl.sv
// Port-B controller: forwards the start-up clear, then read-streams-clears all bins per frame.
// Latency: init passthrough 1 cycle; sweep RD at t+1 after frame_done, BINS*(1+RD_LAT) cycles.
// Backpressure: none; the CDF stage must take every hist_out_valid pulse.
module hist_portb_ctrl
    import hist_portb_ctrl_pkg::*;
#(
    parameter int TILES  = HIST_TILES,
    parameter int BINS   = HIST_BINS,
    parameter int DW     = HIST_DW,
    parameter int RD_LAT = HIST_RD_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_done,
    hist_portb_ctrl_if.slave bus,
    output logic             busy,
    output logic             sweep_done,
    output logic             overrun
);
    st_e        st_q;
    st_e        st_nxt;
    logic [7:0] cur_bin;
    logic [7:0] nxt_bin;
    logic       last_bin;
    logic       pend_q;
    logic       sweeping;

    assign sweeping = (st_q == ST_RD) || (st_q == ST_WAIT) || (st_q == ST_CLR);
    assign busy     = sweeping || pend_q;

    hist_bin_sweeper #(
        .BINS   (BINS),
        .RD_LAT (RD_LAT)
    ) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .init_flag (bus.init_flag),
        .start     (frame_done || pend_q),
        .st_q      (st_q),
        .st_nxt    (st_nxt),
        .cur_bin   (cur_bin),
        .nxt_bin   (nxt_bin),
        .last_bin  (last_bin)
    );

    // Port-B drive, registered from the next state; init_* is only looked at while init_flag=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.portb_addr <= '0;
            bus.portb_data <= {DW{1'b0}};
            bus.portb_wren <= {TILES{1'b0}};
        end else begin
            bus.portb_data <= {DW{1'b0}};
            bus.portb_wren <= {TILES{1'b0}};
            case (st_nxt)
                ST_INIT: begin
                    bus.portb_addr <= bus.init_addr;
                    bus.portb_data <= bus.init_data;
                    bus.portb_wren <= bus.init_wren;
                end
                ST_RD:   bus.portb_addr <= nxt_bin;
                ST_CLR: begin
                    bus.portb_addr <= nxt_bin;
                    bus.portb_wren <= {TILES{1'b1}};
                end
                default: ;
            endcase
        end
    end

    // Capture the read data during CLR and present it the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.hist_out_valid <= 1'b0;
            bus.hist_out_bin   <= '0;
            bus.hist_out_data  <= '0;
            sweep_done         <= 1'b0;
        end else begin
            bus.hist_out_valid <= (st_q == ST_CLR);
            sweep_done         <= (st_q == ST_CLR) && last_bin;
            if (st_q == ST_CLR) begin
                bus.hist_out_bin  <= cur_bin;
                bus.hist_out_data <= bus.portb_q;
            end
        end
    end

    // A frame end seen during init is remembered; one seen mid-sweep is flagged and dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if ((st_q == ST_IDLE) && (st_nxt == ST_RD)) begin
                pend_q <= 1'b0;
            end else if (frame_done && (st_nxt == ST_INIT)) begin
                pend_q <= 1'b1;
            end
            if (frame_done && sweeping) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hist_portb_ctrl.sv
// Self-checking bench: behavioural tile RAMs, a reference histogram array and a stream scoreboard.
// Latency: expectations derive from read-then-clear of every bin, (1+RD_LAT) cycles per bin.
// Backpressure: none; every hist_out_valid pulse is consumed and checked.
module tb_hist_portb_ctrl;
    import hist_portb_ctrl_pkg::*;

    localparam int T     = HIST_TILES;
    localparam int B     = HIST_BINS;
    localparam int W     = HIST_DW;
    localparam int LAT   = 1;
    localparam int SWEEP = B * (1 + LAT);

    typedef struct packed {
        logic [7:0]     bin;
        logic [T*W-1:0] data;
    } exp_t;

    logic           clk        = 1'b0;
    logic           rst        = 1'b1;
    logic           frame_done = 1'b0;
    logic           busy;
    logic           sweep_done;
    logic           overrun;
    logic           pa_we      = 1'b0;
    logic [7:0]     pa_addr    = '0;
    logic [T*W-1:0] pa_data    = '0;
    logic [W-1:0]   mem     [T][B];
    logic [W-1:0]   ref_mem [T][B];
    exp_t           sb[$];
    int             cyc     = 0;
    int             n_tests = 0;
    int             n_fail  = 0;

    hist_portb_ctrl_if bus ();

    hist_portb_ctrl #(.RD_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done),
        .bus        (bus),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tile RAMs: port A is the bench's accumulation port, port B belongs to the DUT.
    always @(posedge clk) begin
        for (int k = 0; k < T; k++) begin
            bus.portb_q[k*W +: W] <= mem[k][bus.portb_addr];
            if (bus.portb_wren[k]) mem[k][bus.portb_addr] <= bus.portb_data;
            if (pa_we) mem[k][pa_addr] <= pa_data[k*W +: W];
        end
    end

    // init_flag in the middle of a sweep is an illegal stimulus.
    always @(posedge clk) begin
        if (!rst) assert (!(bus.init_flag && dut.sweeping))
            else $error("init_flag raised during a sweep");
    end

    task automatic chk(input string nm, input logic [T*W-1:0] act, input logic [T*W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.hist_out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL hist_extra: got pulse for bin %0d, expected none", bus.hist_out_bin);
                end else begin
                    e = sb.pop_front();
                    chk("hist_bin", bus.hist_out_bin, e.bin);
                    chk("hist_data", bus.hist_out_data, e.data);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, bus.portb_addr, 0);
        chk({tag, "_data"}, bus.portb_data, 0);
        chk({tag, "_wren"}, bus.portb_wren, 0);
        chk({tag, "_valid"}, bus.hist_out_valid, 0);
        chk({tag, "_bin"}, bus.hist_out_bin, 0);
        chk({tag, "_hdata"}, bus.hist_out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, sweep_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic preload(input bit rnd);
        logic [W-1:0] v;
        for (int b = 0; b < B; b++) begin
            @(posedge clk); #1;
            pa_we   = 1'b1;
            pa_addr = 8'(b);
            for (int k = 0; k < T; k++) begin
                v = rnd ? W'($urandom) : W'(b + k);
                pa_data[k*W +: W] = v;
                ref_mem[k][b]     = v;
            end
        end
        @(posedge clk); #1;
        pa_we = 1'b0;
    endtask

    // Expected stream: read bins in ascending order; every bin read (and the one in CLR) is zeroed.
    task automatic push_sweep(input int npush, input int nclear);
        for (int b = 0; b < nclear; b++) begin
            exp_t e;
            e.bin = 8'(b);
            for (int k = 0; k < T; k++) begin
                e.data[k*W +: W] = ref_mem[k][b];
                ref_mem[k][b]    = '0;
            end
            if (b < npush) sb.push_back(e);
        end
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        for (int k = 0; k < T; k++)
            for (int b = 0; b < B; b++)
                if (mem[k][b] !== ref_mem[k][b]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic start_sweep(output int n0);
        @(posedge clk); #1;
        frame_done = 1'b1;
        n0 = cyc;
        @(negedge clk);
        chk("busy_before", busy, 0);
        @(posedge clk); #1;
        frame_done = 1'b0;
        @(negedge clk);
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_done(input int n0, input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                lat = cyc - n0;
                break;
            end
        end
    endtask

    task automatic run_init(input int n, input bit rnd, input int fd_at, output int t_drop);
        logic [7:0]   a;
        logic [7:0]   pa = '0;
        logic [T-1:0] w;
        logic [T-1:0] pw = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
            w = rnd ? T'($urandom) : {T{1'b1}};
            bus.init_flag = 1'b1;
            bus.init_addr = a;
            bus.init_data = '0;
            bus.init_wren = w;
            frame_done    = (i == fd_at);
            for (int k = 0; k < T; k++) if (w[k]) ref_mem[k][a] = '0;
            @(negedge clk);
            if (i > 0) begin
                chk("init_addr", bus.portb_addr, pa);
                chk("init_wren", bus.portb_wren, pw);
            end
            if (fd_at >= 0 && i == fd_at + 1) chk("busy_pending", busy, 1);
            pa = a;
            pw = w;
        end
        @(posedge clk); #1;
        bus.init_flag = 1'b0;
        bus.init_addr = 'z;
        bus.init_data = 'z;
        bus.init_wren = 'z;
        frame_done    = 1'b0;
        t_drop        = cyc;
        @(negedge clk);
        chk("init_last_addr", bus.portb_addr, pa);
        chk("init_last_wren", bus.portb_wren, pw);
        @(negedge clk);
        chk("init_drop_wren", bus.portb_wren, 0);
        chk("init_drop_data", bus.portb_data, 0);
        chk("init_hold_addr", bus.portb_addr, pa);
    endtask

    initial begin
        int n0;
        int lat;
        int busy_cnt;
        bus.init_flag = 1'b0;
        bus.init_addr = '0;
        bus.init_data = '0;
        bus.init_wren = '0;
        fork
            monitor();
        join_none

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        chk("wren_known", $isunknown(bus.portb_wren), 0);

        // Start-up clear of every bin through the init passthrough.
        preload(1'b1);
        run_init(B, 1'b0, -1, n0);
        check_mem("init_clear");
        chk("init_overrun", overrun, 0);

        // Full sweep over b+k counts.
        preload(1'b0);
        push_sweep(B, B);
        start_sweep(n0);
        wait_done(n0, SWEEP + 50, lat);
        chk("sweep_latency", lat, SWEEP + 1);
        chk("busy_fall", busy, 0);
        @(negedge clk);
        chk("done_pulse", sweep_done, 0);
        repeat (2) @(negedge clk);
        chk("sb_drained_1", sb.size(), 0);
        check_mem("sweep_clear");

        // frame_done during a random init sequence: sweep runs after init via IDLE.
        preload(1'b1);
        run_init(40, 1'b1, 10, n0);
        push_sweep(B, B);
        wait_done(n0, SWEEP + 50, lat);
        chk("pend_latency", lat, SWEEP + 2);
        chk("pend_overrun", overrun, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained_2", sb.size(), 0);
        check_mem("pend_clear");

        // Second frame_done at bin 100 is flagged and dropped.
        preload(1'b1);
        push_sweep(B, B);
        start_sweep(n0);
        repeat (200) @(posedge clk);
        #1 frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        wait_done(n0, SWEEP + 50, lat);
        chk("ovr_latency", lat, SWEEP + 1);
        busy_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("no_second_sweep", busy_cnt, 0);
        chk("overrun_sticky", overrun, 1);
        chk("sb_drained_3", sb.size(), 0);
        check_mem("ovr_clear");

        // Reset while bin 40 is in CLR: bins 0..39 streamed, 0..40 cleared, 41..255 untouched.
        preload(1'b1);
        push_sweep(40, 41);
        start_sweep(n0);
        repeat (81) @(posedge clk);
        @(negedge clk);
        chk("clr40_addr", bus.portb_addr, 40);
        chk("clr40_wren", bus.portb_wren, {T{1'b1}});
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy || bus.portb_wren != 0) busy_cnt++;
        end
        chk("rst_quiet", busy_cnt, 0);
        chk("sb_drained_4", sb.size(), 0);
        check_mem("rst_keep");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
